his_readout_fsm: RTL and testbench

- Drains a completed ping-pong histogram bank after the histogram builder signals end of acquisition.
- Reads every bin of every pixel from the bank the builder is not writing and streams each bin out over a valid/ready interface.
- Zeroes each bin after it is accepted, so the bank is clean for the next acquisition.
- Reports the peak bin of each pixel (index and count) for downstream ToF distance extraction.

---
 rtl/his_readout_fsm.sv | 164 ++++++++++++++++
 tb/tb_his_readout_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/his_readout_fsm.sv
// Histogram bank readout: drains the idle ping-pong bank bin by bin over a
// valid/ready stream, zeroes each accepted bin and reports the per-pixel peak.
module his_readout_fsm #(
  parameter int unsigned BIN_NUM   = 64,
  parameter int unsigned BIN_W     = 6,
  parameter int unsigned PIXEL_NUM = 200,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned CNT_W     = 10
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     acq_done,
  input  logic                     his_num,
  output logic                     rd_en,
  output logic [PIX_W+BIN_W:0]     rd_addr,
  input  logic [CNT_W-1:0]         rd_data,
  output logic                     clr_en,
  output logic [PIX_W+BIN_W:0]     clr_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_data,
  output logic [BIN_W-1:0]         out_bin,
  output logic [PIX_W-1:0]         out_pix,
  output logic                     peak_valid,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [CNT_W-1:0]         peak_cnt,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int unsigned ADDR_W = 1 + PIX_W + BIN_W;

  typedef enum logic [2:0] {IDLE, RD, LD, OUT, PK, DONE} state_t;

  state_t             state, state_d;
  logic               bank, bank_d;
  logic [PIX_W-1:0]   pix, pix_d;
  logic [BIN_W-1:0]   bin, bin_d;
  logic [CNT_W-1:0]   out_data_d, peak_cnt_d;
  logic [BIN_W-1:0]   out_bin_d, peak_bin_d;
  logic [PIX_W-1:0]   out_pix_d;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic               rd_en_d, out_valid_d, peak_valid_d, busy_d, frame_done_d, overrun_d;

  logic               last_bin, last_pix;

  assign last_bin = (bin >= BIN_W'(BIN_NUM - 1));
  assign last_pix = (pix >= PIX_W'(PIXEL_NUM - 1));

  // Zeroing happens on the accept cycle itself, so it tracks the handshake directly.
  always_comb begin
    clr_en   = out_valid & out_ready;
    clr_addr = clr_en ? {bank, out_pix, out_bin} : '0;
  end

  // Next-state, index/peak update and next values of the registered outputs.
  always_comb begin
    state_d    = state;
    bank_d     = bank;
    pix_d      = pix;
    bin_d      = bin;
    out_data_d = out_data;
    out_bin_d  = out_bin;
    out_pix_d  = out_pix;
    peak_bin_d = peak_bin;
    peak_cnt_d = peak_cnt;
    overrun_d  = overrun | (acq_done & (state != IDLE));

    case (state)
      IDLE: begin
        if (acq_done) begin
          // Builder has already flipped to the new bank; drain the other one.
          bank_d     = ~his_num;
          pix_d      = '0;
          bin_d      = '0;
          peak_bin_d = '0;
          peak_cnt_d = '0;
          state_d    = RD;
        end
      end
      RD: state_d = LD;
      LD: begin
        out_data_d = rd_data;
        out_bin_d  = bin;
        out_pix_d  = pix;
        // Strict compare keeps the lowest bin on ties; bin 0 restarts the search.
        if ((rd_data > peak_cnt) || (bin == '0)) begin
          peak_cnt_d = rd_data;
          peak_bin_d = bin;
        end
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (!last_bin) begin
            bin_d   = bin + BIN_W'(1);
            state_d = RD;
          end else begin
            state_d = PK;
          end
        end
      end
      PK: begin
        if (!last_pix) begin
          pix_d   = pix + PIX_W'(1);
          bin_d   = '0;
          state_d = RD;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d      = (state_d == RD);
    rd_addr_d    = rd_en_d ? {bank_d, pix_d, bin_d} : rd_addr;
    out_valid_d  = (state_d == OUT);
    peak_valid_d = (state_d == PK);
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  // State, index, peak and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      bank       <= 1'b0;
      pix        <= '0;
      bin        <= '0;
      out_data   <= '0;
      out_bin    <= '0;
      out_pix    <= '0;
      peak_bin   <= '0;
      peak_cnt   <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      peak_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      bank       <= bank_d;
      pix        <= pix_d;
      bin        <= bin_d;
      out_data   <= out_data_d;
      out_bin    <= out_bin_d;
      out_pix    <= out_pix_d;
      peak_bin   <= peak_bin_d;
      peak_cnt   <= peak_cnt_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      out_valid  <= out_valid_d;
      peak_valid <= peak_valid_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_his_readout_fsm.sv
// Bench for his_readout_fsm: memory model, expected-beat/peak scoreboard and directed frames.
module tb_his_readout_fsm;

  localparam int unsigned ADDR_W = 15;

  typedef struct packed {
    logic       bank;
    logic [7:0] pix;
    logic [5:0] bin;
    logic [9:0] data;
  } beat_t;

  typedef struct packed {
    logic [7:0] pix;
    logic [5:0] bin;
    logic [9:0] cnt;
  } peak_t;

  logic              clk = 1'b0;
  logic              res, acq_done, his_num, out_ready;
  logic              rd_en, clr_en, out_valid, peak_valid, busy, frame_done, overrun;
  logic [ADDR_W-1:0] rd_addr, clr_addr;
  logic [9:0]        rd_data, out_data, peak_cnt;
  logic [5:0]        out_bin, peak_bin;
  logic [7:0]        out_pix;

  int checks = 0;
  int errors = 0;
  int n_beats = 0;
  int n_peaks = 0;
  int n_frames = 0;

  beat_t beat_q[$];
  peak_t peak_q[$];
  bit    cleared [32768];

  always #5 clk = ~clk;

  his_readout_fsm dut (
    .clk(clk), .res(res), .acq_done(acq_done), .his_num(his_num),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bin(out_bin), .out_pix(out_pix),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_cnt(peak_cnt),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ad(input logic b, input int p, input int k);
    return {b, 8'(p), 6'(k)};
  endfunction

  // Preloaded contents: bank 1 has directed pixels 0..2, bank 0 holds p*7+k.
  function automatic logic [9:0] init_val(input logic [ADDR_W-1:0] a);
    logic [7:0] p;
    logic [5:0] k;
    p = a[13:6];
    k = a[5:0];
    if (a[14]) begin
      if (p == 8'd0) return 10'(k);
      if (p == 8'd1) return ((k == 6'd10) || (k == 6'd20)) ? 10'd5 : 10'd0;
      if (p == 8'd2) return 10'(6'd63 - k);
      return 10'd0;
    end
    return 10'(int'(p) * 7 + int'(k));
  endfunction

  // Histogram memory: one-cycle read latency, zero-on-clear.
  always @(posedge clk) begin
    if (rd_en) rd_data <= cleared[rd_addr] ? 10'd0 : init_val(rd_addr);
    if (clr_en) cleared[clr_addr] <= 1'b1;
  end

  // Monitor: compares every accepted beat and every peak pulse against the queues.
  always @(negedge clk) begin
    if (rd_en || clr_en) chk("rd_clr_exclusive", 32'(rd_en & clr_en), 32'd0);
    if (clr_en || (out_valid && out_ready))
      chk("clr_on_handshake", 32'(clr_en), 32'(out_valid & out_ready));
    if (out_valid && out_ready) begin
      n_beats++;
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = beat_q.pop_front();
        chk("beat_pix_bin_data", 32'({out_pix, out_bin, out_data}), 32'({e.pix, e.bin, e.data}));
        chk("clr_addr", 32'(clr_addr), 32'({e.bank, e.pix, e.bin}));
      end
    end
    if (peak_valid) begin
      n_peaks++;
      if (peak_q.size() == 0) begin
        chk("peak_unexpected", 32'd1, 32'd0);
      end else begin
        peak_t e;
        e = peak_q.pop_front();
        chk("peak_pix_bin_cnt", 32'({out_pix, peak_bin, peak_cnt}), 32'({e.pix, e.bin, e.cnt}));
      end
    end
    if (frame_done) n_frames++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd(input logic [ADDR_W-1:0] a, input int budget, input string nm);
    int n = 0;
    while (!(rd_en && (rd_addr == a)) && (n < budget)) begin
      tick();
      n++;
    end
    chk(nm, 32'(rd_en && (rd_addr == a)), 32'd1);
  endtask

  task automatic push_beat(input logic b, input int p, input int k);
    beat_t e;
    e.bank = b;
    e.pix  = 8'(p);
    e.bin  = 6'(k);
    e.data = cleared[ad(b, p, k)] ? 10'd0 : init_val(ad(b, p, k));
    beat_q.push_back(e);
  endtask

  task automatic push_peak(input int p, input int k, input int c);
    peak_t e;
    e.pix = 8'(p);
    e.bin = 6'(k);
    e.cnt = 10'(c);
    peak_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'({out_valid, busy, overrun, clr_en, rd_en, peak_valid, frame_done}), 32'd0);
    chk({nm, "_addr"}, 32'({rd_addr, clr_addr}), 32'd0);
    chk({nm, "_data"}, 32'({out_data, out_bin, out_pix}), 32'd0);
    chk({nm, "_peak"}, 32'({peak_bin, peak_cnt}), 32'd0);
  endtask

  initial begin
    int n;
    int c;
    res = 1'b0; acq_done = 1'b0; his_num = 1'b0; out_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1 res = 1'b1;
    tick(); tick();
    chk("idle_not_busy", 32'({busy, rd_en, out_valid}), 32'd0);

    // Frame A: drain bank 1 (his_num = 0), all 200 pixels.
    for (int p = 0; p < 200; p++)
      for (int k = 0; k < 64; k++) push_beat(1'b1, p, k);
    push_peak(0, 63, 63);
    push_peak(1, 10, 5);
    push_peak(2, 0, 63);
    for (int p = 3; p < 200; p++) push_peak(p, 0, 0);

    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    chk("first_rd", 32'({busy, rd_en, rd_addr}), 32'({2'b11, ad(1'b1, 0, 0)}));
    tick();
    chk("ld_no_valid", 32'(out_valid), 32'd0);
    tick();
    chk("latency_valid", 32'({out_valid, out_bin, out_pix, out_data}), 32'({1'b1, 24'd0}));

    // Backpressure on pixel 2 bin 3.
    wait_rd(ad(1'b1, 2, 3), 2000, "wait_p2_b3");
    out_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("stall_hold", 32'({out_valid, clr_en, rd_en, out_pix, out_bin, out_data}),
          32'({3'b100, 8'd2, 6'd3, 10'd60}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_clr", 32'({clr_en, clr_addr}), 32'({1'b1, ad(1'b1, 2, 3)}));
    tick();
    chk("stall_next_rd", 32'({rd_en, rd_addr}), 32'({1'b1, ad(1'b1, 2, 4)}));

    // Mid-frame acq_done with the other bank selected: overrun only.
    wait_rd(ad(1'b1, 4, 0), 2000, "wait_p4_b0");
    his_num = 1'b1;
    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    chk("overrun_set", 32'({overrun, busy}), 32'd3);

    n = 0;
    while (!frame_done && (n < 45000)) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 32'({frame_done, busy}), 32'd3);
    tick();
    chk("idle_after_done", 32'({busy, frame_done, overrun}), 32'd1);
    tick(); tick();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("frame_a_beats", 32'(n_beats), 32'd12800);
    chk("frame_a_peaks", 32'(n_peaks), 32'd200);
    chk("frame_a_frames", 32'(n_frames), 32'd1);
    chk("frame_a_queues", 32'(beat_q.size() + peak_q.size()), 32'd0);
    c = 0;
    for (int a = 16384; a < 32768; a++) c += int'(cleared[a]);
    chk("bank1_all_cleared", 32'(c), 32'd12800);
    c = 0;
    for (int a = 0; a < 16384; a++) c += int'(cleared[a]);
    chk("bank0_untouched", 32'(c), 32'd0);

    // Frame B: drain bank 0, reset during OUT of pixel 5 bin 30.
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 64; k++) push_beat(1'b0, p, k);
    for (int k = 0; k < 30; k++) push_beat(1'b0, 5, k);
    push_peak(0, 63, 63);
    push_peak(1, 63, 70);
    push_peak(2, 63, 77);
    push_peak(3, 63, 84);
    push_peak(4, 63, 91);
    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    chk("b_first_rd", 32'({rd_en, rd_addr}), 32'({1'b1, ad(1'b0, 0, 0)}));
    wait_rd(ad(1'b0, 5, 30), 3000, "wait_p5_b30");
    out_ready = 1'b0;
    tick();
    tick();
    chk("b_out_p5_b30", 32'({out_valid, out_pix, out_bin, out_data}),
        32'({1'b1, 8'd5, 6'd30, 10'd65}));
    #2 res = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick(); tick();
    chk("no_clr_b30", 32'(cleared[ad(1'b0, 5, 30)]), 32'd0);
    chk("clr_b29", 32'(cleared[ad(1'b0, 5, 29)]), 32'd1);
    chk("frame_b_queues", 32'(beat_q.size() + peak_q.size()), 32'd0);
    chk("frame_b_beats", 32'(n_beats), 32'd13150);
    chk("frame_b_peaks", 32'(n_peaks), 32'd205);

    // Restart after reset: begins at pixel 0 bin 0, which now reads cleared zeros.
    res = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) push_beat(1'b0, 0, k);
    push_peak(0, 0, 0);
    acq_done = 1'b1;
    tick();
    acq_done = 1'b0;
    chk("restart_rd", 32'({rd_en, rd_addr, overrun}), 32'({1'b1, ad(1'b0, 0, 0), 1'b0}));
    wait_rd(ad(1'b0, 1, 0), 1000, "wait_restart_p1");
    res = 1'b0;
    tick();
    res = 1'b1;
    tick();
    chk("restart_queues", 32'(beat_q.size() + peak_q.size()), 32'd0);
    chk("restart_beats", 32'(n_beats), 32'd13214);
    chk("total_frames", 32'(n_frames), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
